// File: rtl/alu_op_dispatcher.sv
// alu_op_dispatcher: accepts one ALU request at a time, decodes the upper select bits of
// ALU_FUN into a one-hot unit enable, holds the sub-op for the selected unit and waits for
// that unit's Done strobe. Completion, illegal select and abort are reported as one-cycle
// pulses.
// Optional feature: define DISPATCH_TIMEOUT_EN to add an 8-bit BUSY cycle counter that
// aborts an operation after TIMEOUT_CYC cycles without Done.
module alu_op_dispatcher #(
    parameter int unsigned NUM_UNITS   = 4,
    parameter int unsigned FUN_W       = 4,
    parameter int unsigned TIMEOUT_CYC = 15,
    localparam int unsigned SEL_W      = $clog2(NUM_UNITS),
    localparam int unsigned OP_W       = FUN_W - SEL_W
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [FUN_W-1:0]     ALU_FUN,
    input  logic                 Enable_ALU,
    output logic                 Req_Ready,
    output logic [NUM_UNITS-1:0] Unit_Enable,
    output logic [OP_W-1:0]      Unit_Op,
    input  logic [NUM_UNITS-1:0] Unit_Done,
    output logic                 OUT_Valid,
    output logic                 Illegal_Op,
    output logic                 Timeout
);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e               state_q, state_d;
    logic [NUM_UNITS-1:0] enable_q, enable_d;
    logic [OP_W-1:0]      op_q, op_d;
    logic                 valid_q, valid_d;
    logic                 illegal_q, illegal_d;
    logic                 timeout_d;

    logic [SEL_W-1:0]     sel;
    logic [OP_W-1:0]      sub_op;
    logic                 sel_legal;
    logic [NUM_UNITS-1:0] sel_onehot;
    logic                 done_hit;
    logic                 timeout_hit;

    assign sel    = ALU_FUN[FUN_W-1 -: SEL_W];
    assign sub_op = ALU_FUN[OP_W-1:0];

    // Select decode; only values below NUM_UNITS address a real unit
    always_comb begin
        sel_legal  = (32'(sel) < NUM_UNITS);
        sel_onehot = '0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            sel_onehot[i] = (32'(sel) == i);
        end
    end

    // The enable register is one-hot on the active unit, so masking Done with it
    // ignores strobes from every other unit and from all units while idle.
    assign done_hit = |(Unit_Done & enable_q);

`ifdef DISPATCH_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q;

    // Abort when the cycle now ending is the TIMEOUT_CYC-th BUSY cycle; Done takes priority
    assign timeout_hit = (state_q == StBusy) && !done_hit && (cnt_q == 8'(TIMEOUT_CYC - 1));

    // BUSY cycle counter: cleared on acceptance, advances each BUSY cycle
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            if (Enable_ALU && sel_legal) begin
                cnt_d = '0;
            end
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Counter and abort pulse registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign Timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign Timeout     = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: accept a legal request in IDLE, leave BUSY on Done or abort
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (Enable_ALU && sel_legal) begin
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (done_hit || timeout_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: ready flag plus next values of the registered enable, op and pulses
    always_comb begin
        Req_Ready = (state_q == StIdle);
        enable_d  = enable_q;
        op_d      = op_q;
        valid_d   = 1'b0;
        illegal_d = 1'b0;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Enable_ALU) begin
                    if (sel_legal) begin
                        enable_d = sel_onehot;
                        op_d     = sub_op;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            StBusy: begin
                if (done_hit) begin
                    valid_d  = 1'b1;
                    enable_d = '0;
                end else if (timeout_hit) begin
                    timeout_d = 1'b1;
                    enable_d  = '0;
                end
            end
            default: enable_d = '0;
        endcase
    end

    // Registered unit interface and completion/illegal pulses
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            enable_q  <= '0;
            op_q      <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            enable_q  <= enable_d;
            op_q      <= op_d;
            valid_q   <= valid_d;
            illegal_q <= illegal_d;
        end
    end

    assign Unit_Enable = enable_q;
    assign Unit_Op     = op_q;
    assign OUT_Valid   = valid_q;
    assign Illegal_Op  = illegal_q;

endmodule

// File: tb/tb_alu_op_dispatcher.sv
// Self-checking bench for alu_op_dispatcher: directed scenarios plus randomized traffic
// against a transaction-level reference model. A second instance with NUM_UNITS=3 covers
// illegal selects. Timeout scenarios run when DISPATCH_TIMEOUT_EN is defined.
module tb_alu_op_dispatcher;

    localparam int NU  = 4;
    localparam int OPW = 2;
    localparam int TO  = 15;
`ifdef DISPATCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST = 1'b1;

    logic [3:0] fun, done, uen;
    logic       en, rdy, val, ill, tmo;
    logic [1:0] uop;

    logic [3:0] fun3;
    logic [2:0] done3, uen3;
    logic       en3, rdy3, val3, ill3, tmo3;
    logic [1:0] uop3;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_busy;
    int m_unit, m_op, m_cnt;
    bit m_valid, m_ill, m_to;

    always #5 CLK = ~CLK;

    alu_op_dispatcher dut (
        .CLK(CLK), .RST(RST), .ALU_FUN(fun), .Enable_ALU(en), .Req_Ready(rdy),
        .Unit_Enable(uen), .Unit_Op(uop), .Unit_Done(done), .OUT_Valid(val),
        .Illegal_Op(ill), .Timeout(tmo)
    );

    alu_op_dispatcher #(.NUM_UNITS(3)) dut3 (
        .CLK(CLK), .RST(RST), .ALU_FUN(fun3), .Enable_ALU(en3), .Req_Ready(rdy3),
        .Unit_Enable(uen3), .Unit_Op(uop3), .Unit_Done(done3), .OUT_Valid(val3),
        .Illegal_Op(ill3), .Timeout(tmo3)
    );

    function automatic logic [9:0] actual();
        return {rdy, uen, uop, val, ill, tmo};
    endfunction

    function automatic logic [9:0] expected();
        logic [3:0] e;
        e = m_busy ? 4'(1 << m_unit) : 4'b0000;
        return {~m_busy, e, 2'(m_op), m_valid, m_ill, m_to};
    endfunction

    task automatic model_reset();
        m_busy = 0; m_unit = 0; m_op = 0; m_cnt = 0;
        m_valid = 0; m_ill = 0; m_to = 0;
    endtask

    // One clock edge of the behavioural model, from the inputs seen at that edge
    task automatic model_edge(input logic [3:0] f, input logic e, input logic [3:0] d);
        int s;
        s = int'(f) >> OPW;
        m_valid = 0; m_ill = 0; m_to = 0;
        if (!m_busy) begin
            if (e) begin
                if (s < NU) begin
                    m_busy = 1; m_unit = s; m_op = int'(f) % (1 << OPW); m_cnt = 0;
                end else begin
                    m_ill = 1;
                end
            end
        end else if (d[m_unit]) begin
            m_valid = 1; m_busy = 0;
        end else begin
            m_cnt++;
            if (TO_EN && m_cnt == TO) begin
                m_to = 1; m_busy = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_edge(fun, en, done);
        #1;
    endtask

    task automatic test_reset();
        #2 RST = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (actual() !== 10'b1_0000_00_000) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b expected %b", actual(), 10'b1_0000_00_000);
        end
        n_checks++;
        if ({rdy3, uen3, uop3, val3, ill3, tmo3} !== 9'b1_000_00_000) begin
            n_errors++;
            $display("FAIL reset_outputs3: got %b expected %b",
                     {rdy3, uen3, uop3, val3, ill3, tmo3}, 9'b1_000_00_000);
        end
        @(negedge CLK) RST = 1'b1;
    endtask

    task automatic test_single_op();
        fun = 4'b1001; en = 1'b1; done = 4'b0000;
        cycle();
        n_checks++;
        if (uen !== 4'b0100 || uop !== 2'b01 || rdy !== 1'b0) begin
            n_errors++;
            $display("FAIL single_issue: got en=%b op=%b rdy=%b expected en=0100 op=01 rdy=0",
                     uen, uop, rdy);
        end
        en = 1'b0; done = 4'b0100;
        cycle();
        n_checks++;
        if (actual() !== expected() || val !== 1'b1 || rdy !== 1'b1) begin
            n_errors++;
            $display("FAIL single_done: got %b expected %b", actual(), expected());
        end
        done = 4'b0000;
        cycle();
        n_checks++;
        if (actual() !== expected() || val !== 1'b0) begin
            n_errors++;
            $display("FAIL single_pulse_end: got %b expected %b", actual(), expected());
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] en_seq [3];
        logic       val_seq [4];
        fun = 4'b0011; en = 1'b1; done = 4'b0000;
        cycle();
        en_seq[0] = uen; val_seq[0] = val;
        fun = 4'b1110; done = 4'b0001;
        cycle();
        en_seq[1] = uen; val_seq[1] = val;
        done = 4'b1000;  // arrives while idle: must be ignored
        cycle();
        en_seq[2] = uen; val_seq[2] = val;
        en = 1'b0; done = 4'b1000;
        cycle();
        val_seq[3] = val;
        n_checks++;
        if (actual() !== expected()) begin
            n_errors++;
            $display("FAIL b2b_model: got %b expected %b", actual(), expected());
        end
        n_checks++;
        if ({en_seq[0], en_seq[1], en_seq[2]} !== 12'b0001_0000_1000) begin
            n_errors++;
            $display("FAIL b2b_enable_seq: got %b %b %b expected 0001 0000 1000",
                     en_seq[0], en_seq[1], en_seq[2]);
        end
        n_checks++;
        if ({val_seq[0], val_seq[1], val_seq[2], val_seq[3]} !== 4'b0101) begin
            n_errors++;
            $display("FAIL b2b_valid_seq: got %b%b%b%b expected 0101",
                     val_seq[0], val_seq[1], val_seq[2], val_seq[3]);
        end
        done = 4'b0000;
        cycle();
    endtask

    task automatic test_busy_ignore();
        fun = 4'b0010; en = 1'b1; done = 4'b0000;
        cycle();
        fun = 4'b0100; done = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            cycle();
            n_checks++;
            if (actual() !== expected() || uen !== 4'b0001 || uop !== 2'b10) begin
                n_errors++;
                $display("FAIL busy_ignore[%0d]: got %b expected %b", i, actual(), expected());
            end
        end
        en = 1'b0; done = 4'b0001;
        cycle();
        n_checks++;
        if (actual() !== expected() || val !== 1'b1) begin
            n_errors++;
            $display("FAIL busy_done: got %b expected %b", actual(), expected());
        end
        done = 4'b0000;
        cycle();
    endtask

    task automatic test_illegal();
        fun3 = 4'b1100; en3 = 1'b1; done3 = 3'b111;
        @(posedge CLK); #1;
        n_checks++;
        if ({rdy3, uen3, val3, ill3, tmo3} !== 7'b1_000_010) begin
            n_errors++;
            $display("FAIL illegal_pulse: got %b expected 1000010",
                     {rdy3, uen3, val3, ill3, tmo3});
        end
        en3 = 1'b0; done3 = 3'b000;
        @(posedge CLK); #1;
        n_checks++;
        if ({rdy3, uen3, val3, ill3, tmo3} !== 7'b1_000_000) begin
            n_errors++;
            $display("FAIL illegal_end: got %b expected 1000000",
                     {rdy3, uen3, val3, ill3, tmo3});
        end
        fun3 = 4'b1001; en3 = 1'b1;
        @(posedge CLK); #1;
        n_checks++;
        if ({rdy3, uen3, uop3, ill3} !== 7'b0_100_01_0) begin
            n_errors++;
            $display("FAIL legal3_issue: got %b expected 0100010", {rdy3, uen3, uop3, ill3});
        end
        en3 = 1'b0; done3 = 3'b100;
        @(posedge CLK); #1;
        n_checks++;
        if ({rdy3, uen3, val3} !== 5'b1_000_1) begin
            n_errors++;
            $display("FAIL legal3_done: got %b expected 10001", {rdy3, uen3, val3});
        end
        done3 = 3'b000;
    endtask

    task automatic test_reset_mid_busy();
        fun = 4'b1011; en = 1'b1; done = 4'b0000;
        cycle();
        en = 1'b0;
        #2 RST = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (actual() !== 10'b1_0000_00_000) begin
            n_errors++;
            $display("FAIL reset_busy: got %b expected %b", actual(), 10'b1_0000_00_000);
        end
        done = 4'b1000;
        @(posedge CLK); #1;
        n_checks++;
        if (actual() !== 10'b1_0000_00_000) begin
            n_errors++;
            $display("FAIL reset_busy_hold: got %b expected %b", actual(), 10'b1_0000_00_000);
        end
        @(negedge CLK) RST = 1'b1;
        done = 4'b0000;
        cycle();
        n_checks++;
        if (actual() !== expected()) begin
            n_errors++;
            $display("FAIL reset_release: got %b expected %b", actual(), expected());
        end
    endtask

`ifdef DISPATCH_TIMEOUT_EN
    task automatic test_timeout();
        for (int pass = 0; pass < 2; pass++) begin
            fun = 4'b0111; en = 1'b1; done = 4'b0000;
            cycle();
            en = 1'b0;
            for (int c = 1; c <= TO; c++) begin
                // Second pass: Done lands in the cycle the abort would fire
                done = (pass == 1 && c == TO) ? 4'b0010 : 4'b0000;
                cycle();
                n_checks++;
                if (actual() !== expected()) begin
                    n_errors++;
                    $display("FAIL timeout[%0d][%0d]: got %b expected %b",
                             pass, c, actual(), expected());
                end
            end
            n_checks++;
            if ({tmo, val, uen} !== ((pass == 0) ? 6'b10_0000 : 6'b01_0000)) begin
                n_errors++;
                $display("FAIL timeout_end[%0d]: got tmo=%b val=%b en=%b", pass, tmo, val, uen);
            end
            done = 4'b0000;
            cycle();
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            fun  = 4'($urandom);
            en   = 1'($urandom_range(0, 1));
            done = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            cycle();
            n_checks++;
            if (actual() !== expected()) begin
                n_errors++;
                $display("FAIL random[%0d]: got %b expected %b", i, actual(), expected());
            end
        end
        en = 1'b0; done = 4'b0000;
    endtask

    initial begin
        fun = '0; en = 1'b0; done = '0;
        fun3 = '0; en3 = 1'b0; done3 = '0;
        model_reset();
        test_reset();
        test_single_op();
        test_back_to_back();
        test_busy_ignore();
        test_illegal();
        test_reset_mid_busy();
`ifdef DISPATCH_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
